bin2bcd_seq: RTL and testbench
==============================

Name: bin2bcd_seq

Overview:
- Sequential binary-to-BCD converter for the pump display path.
- Implements shift-and-add-3 (double dabble): one left shift per clock, with the per-digit add-3 correction applied before each shift.
- Correction rule per 4-bit digit: values 0–4 pass unchanged; values 5–9 become value+3.
- Accepts a binary value (level, timer, flow count) on a start strobe, converts it in BIN_W cycles, then presents packed BCD digits with a done pulse.

Parameters:
- BIN_W, 8, width of the binary input; also the number of conversion cycles.
- DIGITS, 3, number of BCD output digits. Must satisfy 10^DIGITS > 2^BIN_W − 1. Simulation elaboration check with $error if violated.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  request conversion of bin; honoured only when not busy.
- bin  input  BIN_W  binary value; sampled on the accepting edge only.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse; bcd valid and updated in this cycle.
- bcd  output  4*DIGITS  packed BCD result; digit 0 (units) in bits [3:0]; holds the last result until the next done.

Behaviour:
- Reset: clock and reset are a single clock domain; reset is synchronous and active-high.
  - On rst=1 at a clock edge: state=IDLE, busy=0, done=0, bcd=0, internal shift/scratch registers=0, cycle counter=0.
  - Reset has priority over start and aborts any conversion mid-operation. No done is emitted and bcd stays 0.
- States: IDLE, CONV.
  - IDLE: busy=0. At the first edge with start=1:
    - capture bin into the shift register;
    - clear the BCD scratch register;
    - cnt=0; go to CONV.
  - CONV: busy=1. Each edge:
    - every scratch digit ≥5 gets +3 (4-bit result, no carry between digits);
    - then {scratch, shift} shifts left by 1, MSB of shift entering the scratch LSB;
    - cnt increments.
  - Exit from CONV: the edge performing shift number BIN_W (cnt==BIN_W−1):
    - loads bcd with the post-shift scratch value;
    - sets done=1 for the next cycle;
    - returns to IDLE.
- Timing: start sampled at edge E0.
  - busy=1 for cycles E0+1 through E0+BIN_W.
  - done=1 with new bcd in cycle E0+BIN_W+1, busy=0 in that cycle.
  - Start-to-done latency is BIN_W+1 cycles.
- start while busy=1: ignored, not queued. bin changes during CONV have no effect.
- Back-to-back: start=1 during the done cycle (state IDLE) is accepted; busy rises the next cycle.
- done is never asserted for two consecutive cycles.
- The correction is never applied after the final shift.
- Every bcd digit value is always in the range 0–9.

Optional Feature:
- Macro: BIN2BCD_LEAD_BLANK_EN.
- When defined: adds output port blank, DIGITS bits wide, registered and loaded on the same edge as bcd.
  - blank[i]=1 if digit i and all higher digits are zero, for i≥1.
  - blank[0] is always 0.
  - Reset value is all-ones except bit 0 (e.g. 3'b110).
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- rst, then start with bin=8'd255 -> busy high 8 cycles, done 9 cycles after the start edge, bcd=12'h255.
- bin=0, then bin=5, then bin=99, then bin=100 -> bcd=12'h000, 12'h005, 12'h099, 12'h100 respectively, each with exactly one done pulse.
- start with bin=200, pulse start with bin=17 at busy cycle 3 -> second start ignored; done once; bcd=12'h200.
- start with bin=123, rst at busy cycle 4 -> busy=0, done=0, bcd=0 next cycle; no done afterwards. Then bin=42 converts to 12'h042.
- Back-to-back: start held high continuously with bin=1, then bin=250 -> done pulses every 9 cycles; bcd=12'h001, then 12'h250.
- BIN2BCD_LEAD_BLANK_EN defined: bin=7 -> blank=3'b110; bin=0 -> 3'b110; bin=40 -> 3'b100; bin=201 -> 3'b000.

Source files
------------

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter for the pump display path.
// It uses shift-and-add-3 (double dabble) and takes BIN_W cycles per conversion.
// Before each left shift, every scratch digit that is >= 5 gets +3.
//
// Parameters:
//   BIN_W   width of the binary input; also the number of conversion cycles
//   DIGITS  number of BCD digits (10**DIGITS must exceed 2**BIN_W - 1)
//
// Ports:
//   clk    system clock, rising edge
//   rst    synchronous active-high reset
//   start  conversion request, honoured only when not busy
//   bin    binary value, sampled on the accepting edge
//   busy   high while a conversion is in progress
//   done   one-cycle pulse, bcd updated in the same cycle
//   bcd    packed BCD result (digit 0 in [3:0]), held until the next done
//   blank  (BIN2BCD_LEAD_BLANK_EN only) leading-zero blank flags, one per digit
//
// Optional feature macro: BIN2BCD_LEAD_BLANK_EN
//
// state | meaning
// IDLE  | waiting for start, result registers hold the last value
// CONV  | one correct-then-shift step per clock, cnt counts shifts done
module bin2bcd_seq #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
`ifdef BIN2BCD_LEAD_BLANK_EN
  ,
  output logic [DIGITS-1:0]     blank
`endif
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  localparam longint unsigned DEC_CAP = pow10(DIGITS);
  localparam longint unsigned MAX_BIN = (64'd1 << BIN_W) - 64'd1;

  generate
    if (DEC_CAP <= MAX_BIN) begin : g_param_check
      $error("bin2bcd_seq: DIGITS=%0d too small for BIN_W=%0d", DIGITS, BIN_W);
    end
  endgenerate

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  state_t             state_q, state_n;
  logic [BIN_W-1:0]   shift_q, shift_n;
  logic [BCD_W-1:0]   scratch_q, scratch_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic               done_n;
  logic [BCD_W-1:0]   bcd_n;

  logic [BCD_W-1:0]   corrected;
  logic [BCD_W-1:0]   scratch_shifted;
  logic [BIN_W-1:0]   shift_shifted;

  // Add-3 correction per digit (no carry between digits), then one left shift
  // of the combined {scratch, shift} register.
  always_comb begin
    corrected = scratch_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        corrected[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
    {scratch_shifted, shift_shifted} = {corrected, shift_q} << 1;
  end

`ifdef BIN2BCD_LEAD_BLANK_EN
  localparam logic [DIGITS-1:0] BLANK_RST = {DIGITS{1'b1}} << 1;

  logic [DIGITS-1:0] blank_n;
  logic [DIGITS-1:0] blank_load;
  logic              upper_zero;

  // blank[i] means digit i and everything above it is zero; the units digit
  // is always shown, so bit 0 stays low.
  always_comb begin
    blank_load = '0;
    upper_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      upper_zero    = upper_zero & (scratch_shifted[4*i +: 4] == 4'd0);
      blank_load[i] = upper_zero;
    end
  end
`endif

  always_comb begin
    state_n   = state_q;
    shift_n   = shift_q;
    scratch_n = scratch_q;
    cnt_n     = cnt_q;
    done_n    = 1'b0;
    bcd_n     = bcd;
`ifdef BIN2BCD_LEAD_BLANK_EN
    blank_n   = blank;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          shift_n   = bin;
          scratch_n = '0;
          cnt_n     = '0;
          state_n   = CONV;
        end
      end
      CONV: begin
        shift_n   = shift_shifted;
        scratch_n = scratch_shifted;
        cnt_n     = cnt_q + 1'b1;
        // Last shift: result is taken straight after the shift, no correction.
        if (cnt_q == CNT_LAST) begin
          bcd_n   = scratch_shifted;
          done_n  = 1'b1;
          state_n = IDLE;
`ifdef BIN2BCD_LEAD_BLANK_EN
          blank_n = blank_load;
`endif
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      done      <= 1'b0;
      bcd       <= '0;
`ifdef BIN2BCD_LEAD_BLANK_EN
      blank     <= BLANK_RST;
`endif
    end else begin
      state_q   <= state_n;
      shift_q   <= shift_n;
      scratch_q <= scratch_n;
      cnt_q     <= cnt_n;
      done      <= done_n;
      bcd       <= bcd_n;
`ifdef BIN2BCD_LEAD_BLANK_EN
      blank     <= blank_n;
`endif
    end
  end

  assign busy = (state_q == CONV);

endmodule

// File: tb/tb_bin2bcd_seq.sv
module tb_bin2bcd_seq;

  localparam int BIN_W  = 8;
  localparam int DIGITS = 3;
  localparam int BCD_W  = 4 * DIGITS;

  logic               clk;
  logic               rst;
  logic               start;
  logic [BIN_W-1:0]   bin;
  logic               busy;
  logic               done;
  logic [BCD_W-1:0]   bcd;
`ifdef BIN2BCD_LEAD_BLANK_EN
  logic [DIGITS-1:0]  blank;
`endif

  int checks = 0;
  int errors = 0;

  bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd)
`ifdef BIN2BCD_LEAD_BLANK_EN
    ,
    .blank (blank)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: decimal digits by plain arithmetic.
  function automatic logic [BCD_W-1:0] ref_bcd(input int v);
    logic [BCD_W-1:0] r;
    int p;
    r = '0;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  // Digit i (i>=1) is blank when the value has fewer than i+1 decimal digits.
  function automatic logic [DIGITS-1:0] ref_blank(input int v);
    logic [DIGITS-1:0] b;
    int p;
    b = '0;
    p = 10;
    for (int i = 1; i < DIGITS; i++) begin
      b[i] = (v < p);
      p = p * 10;
    end
    return b;
  endfunction

  // Full conversion with cycle-exact timing checks; leaves start low.
  task automatic conv(input int v, input logic [BCD_W-1:0] exp, input string name);
    start = 1'b1;
    bin   = BIN_W'(v);
    tick();
    start = 1'b0;
    bin   = ~BIN_W'(v);
    for (int k = 1; k <= BIN_W; k++) begin
      chk({name, "_busy"}, busy, 1'b1);
      chk({name, "_nodone"}, done, 1'b0);
      tick();
    end
    chk({name, "_done"}, done, 1'b1);
    chk({name, "_busy_low"}, busy, 1'b0);
    chk({name, "_bcd"}, bcd, exp);
`ifdef BIN2BCD_LEAD_BLANK_EN
    chk({name, "_blank"}, blank, ref_blank(v));
`endif
    tick();
    chk({name, "_done_once"}, done, 1'b0);
    chk({name, "_hold"}, bcd, exp);
  endtask

  typedef struct {
    int               v;
    logic [BCD_W-1:0] exp;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int c;
    int nd;
    int rv;
    logic prev_done;

    vecs[0] = '{0,   12'h000};
    vecs[1] = '{5,   12'h005};
    vecs[2] = '{99,  12'h099};
    vecs[3] = '{100, 12'h100};
    vecs[4] = '{9,   12'h009};
    vecs[5] = '{10,  12'h010};
    vecs[6] = '{199, 12'h199};
    vecs[7] = '{4,   12'h004};

    rst = 1'b1; start = 1'b1; bin = 8'd55;
    tick();
    tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_bcd", bcd, '0);
`ifdef BIN2BCD_LEAD_BLANK_EN
    chk("rst_blank", blank, 3'b110);
`endif
    rst = 1'b0; start = 1'b0;
    tick();
    chk("idle_busy", busy, 1'b0);

    conv(255, 12'h255, "c255");

    foreach (vecs[i]) conv(vecs[i].v, vecs[i].exp, "tbl");

`ifdef BIN2BCD_LEAD_BLANK_EN
    conv(7,   ref_bcd(7),   "blk7");
    conv(0,   ref_bcd(0),   "blk0");
    conv(40,  ref_bcd(40),  "blk40");
    conv(201, ref_bcd(201), "blk201");
`endif

    // Second start during busy must be ignored.
    start = 1'b1; bin = 8'd200;
    tick();                       // busy cycle 1
    start = 1'b0;
    tick();
    tick();                       // busy cycle 3
    start = 1'b1; bin = 8'd17;
    tick();
    start = 1'b0;
    c = 4; nd = 0;
    for (int k = 0; k < 16; k++) begin
      if (done) begin
        nd++;
        chk("ign_done_cycle", c, 9);
        chk("ign_bcd", bcd, 12'h200);
      end
      tick();
      c++;
    end
    chk("ign_done_count", nd, 1);

    // Reset in the middle of a conversion.
    start = 1'b1; bin = 8'd123;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();                       // busy cycle 4
    chk("abort_busy_pre", busy, 1'b1);
    rst = 1'b1;
    tick();
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_bcd", bcd, '0);
    rst = 1'b0;
    nd = 0;
    for (int k = 0; k < 12; k++) begin
      if (done) nd++;
      tick();
    end
    chk("abort_no_done", nd, 0);
    chk("abort_bcd_hold", bcd, '0);
    conv(42, 12'h042, "after_abort");

    // Back-to-back with start held high.
    start = 1'b1; bin = 8'd1;
    tick();
    bin = 8'd250;
    nd = 0;
    prev_done = 1'b0;
    for (c = 1; c <= 19; c++) begin
      if (done) begin
        if (nd == 0) begin
          chk("b2b_first_cycle", c, 9);
          chk("b2b_first_bcd", bcd, 12'h001);
        end else if (nd == 1) begin
          chk("b2b_second_cycle", c, 18);
          chk("b2b_second_bcd", bcd, 12'h250);
        end
        nd++;
      end
      if (done && prev_done) chk("b2b_done_consecutive", 1'b1, 1'b0);
      if (c == 10) chk("b2b_busy_rise", busy, 1'b1);
      prev_done = done;
      tick();
    end
    start = 1'b0;
    chk("b2b_done_count", nd, 2);
    for (int k = 0; k < 12; k++) tick();
    chk("b2b_drained", busy, 1'b0);

    // Random values against the arithmetic reference.
    for (int k = 0; k < 40; k++) begin
      rv = int'($urandom_range(0, 255));
      conv(rv, ref_bcd(rv), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
